// File: rtl/lock_supervisor.sv
// Door-lock sequencer: keypad digit capture, code compare, unlock window, lockout and two-pass programming.
// Optional LOCK_ALARM_EN adds an alarm output (lockout-entry pulse plus pre-alarm one failure before lockout).
module lock_supervisor #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned UNLOCK_CYCLES  = 10,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    input  logic       pressed,
    input  logic       submit,
    input  logic       set_req,
    output logic       unlocked,
    output logic       locked_out,
    output logic       code_valid,
    output logic [1:0] fail_cnt,
`ifdef LOCK_ALARM_EN
    output logic       alarm,
`endif
    output logic [2:0] state_o
);

    localparam int unsigned BUF_W  = 4 * DIGITS;
    localparam int unsigned DCNT_W = $clog2(DIGITS + 1);
    localparam logic [DCNT_W-1:0] DCNT_FULL   = DCNT_W'(DIGITS);
    localparam logic [1:0]        MAX_F       = 2'(MAX_FAILS);
    localparam logic [CNT_W-1:0]  UNLOCK_LOAD = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LOAD   = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        NOCODE   = 3'd0,
        ARMED    = 3'd1,
        OPEN     = 3'd2,
        LOCKOUT  = 3'd3,
        SET_NEW  = 3'd4,
        SET_CONF = 3'd5
    } state_t;

    // Timers must not wrap; out-of-range parameters are rejected at elaboration.
    if (((LOCKOUT_CYCLES >> CNT_W) != 0) || ((UNLOCK_CYCLES >> CNT_W) != 0) ||
        (LOCKOUT_CYCLES == 0) || (UNLOCK_CYCLES == 0) ||
        (MAX_FAILS == 0) || (MAX_FAILS > 3)) begin : g_cfg_error
        $error("lock_supervisor: parameter out of range for CNT_W / fail_cnt width");
    end

    state_t             state_q, state_nx;
    logic [BUF_W-1:0]   code_buf_q, code_buf_nx;
    logic [BUF_W-1:0]   code_q, code_nx;
    logic [BUF_W-1:0]   pending_q, pending_nx;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_nx;
    logic [CNT_W-1:0]   timer_q, timer_nx;
    logic [1:0]         fail_q, fail_nx;
    logic               valid_q, valid_nx;
    logic               unlocked_nx, locked_out_nx;
    logic               capture, full;
    state_t             ret_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NOCODE;
            code_buf_q <= '0;
            code_q     <= '0;
            pending_q  <= '0;
            dcnt_q     <= '0;
            timer_q    <= '0;
            fail_q     <= '0;
            valid_q    <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state_q    <= state_nx;
            code_buf_q <= code_buf_nx;
            code_q     <= code_nx;
            pending_q  <= pending_nx;
            dcnt_q     <= dcnt_nx;
            timer_q    <= timer_nx;
            fail_q     <= fail_nx;
            valid_q    <= valid_nx;
            unlocked   <= unlocked_nx;
            locked_out <= locked_out_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        code_buf_nx = code_buf_q;
        code_nx     = code_q;
        pending_nx  = pending_q;
        dcnt_nx     = dcnt_q;
        timer_nx    = timer_q;
        fail_nx     = fail_q;
        valid_nx    = valid_q;
        capture     = (state_q == NOCODE) || (state_q == ARMED) ||
                      (state_q == SET_NEW) || (state_q == SET_CONF);
        full        = (dcnt_q == DCNT_FULL);
        ret_state   = valid_q ? ARMED : NOCODE;

        // Submit always empties the attempt buffer and beats a same-cycle digit.
        if (submit) begin
            code_buf_nx = '0;
            dcnt_nx     = '0;
        end else if (capture && pressed && (key < 4'd10)) begin
            code_buf_nx = BUF_W'({code_buf_q, key});
            if (!full) dcnt_nx = dcnt_q + DCNT_W'(1);
        end

        case (state_q)
            NOCODE: begin
                if (set_req) state_nx = SET_NEW;
            end
            ARMED: begin
                if (submit) begin
                    if (full && (code_buf_q == code_q)) begin
                        state_nx = OPEN;
                        timer_nx = UNLOCK_LOAD;
                        fail_nx  = '0;
                    end else if (fail_q >= MAX_F - 2'd1) begin
                        state_nx = LOCKOUT;
                        timer_nx = LOCK_LOAD;
                        fail_nx  = MAX_F;
                    end else begin
                        fail_nx = fail_q + 2'd1;
                    end
                end
            end
            OPEN: begin
                if (set_req) begin
                    state_nx = SET_NEW;
                end else if (timer_q == '0) begin
                    state_nx = ARMED;
                end else begin
                    timer_nx = timer_q - CNT_W'(1);
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_nx = ARMED;
                    fail_nx  = '0;
                end else begin
                    timer_nx = timer_q - CNT_W'(1);
                end
            end
            SET_NEW: begin
                if (submit) begin
                    if (full) begin
                        pending_nx = code_buf_q;
                        state_nx   = SET_CONF;
                    end else begin
                        state_nx = ret_state;
                    end
                end
            end
            SET_CONF: begin
                if (submit) begin
                    if (full && (code_buf_q == pending_q)) begin
                        code_nx  = code_buf_q;
                        valid_nx = 1'b1;
                        state_nx = ARMED;
                    end else begin
                        state_nx = ret_state;
                    end
                end
            end
            default: state_nx = NOCODE;
        endcase

        unlocked_nx   = (state_nx == OPEN);
        locked_out_nx = (state_nx == LOCKOUT);
    end

`ifdef LOCK_ALARM_EN
    // Pulse on lockout entry; hold high while one failure short of lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else begin
            alarm <= ((state_nx == LOCKOUT) && (state_q != LOCKOUT)) ||
                     ((state_nx == ARMED) && (fail_nx == MAX_F - 2'd1));
        end
    end
`endif

    assign code_valid = valid_q;
    assign fail_cnt   = fail_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Testbench for lock_supervisor: directed scenarios plus randomized traffic against a decimal-value reference model.
module tb_lock_supervisor;

    localparam int DIGITS         = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 64;
    localparam int UNLOCK_CYCLES  = 10;
    localparam int MOD            = 10000;

    localparam int S_NOCODE = 0, S_ARMED = 1, S_OPEN = 2, S_LOCKOUT = 3, S_SET_NEW = 4, S_SET_CONF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic       pressed = 1'b0;
    logic       submit = 1'b0;
    logic       set_req = 1'b0;
    logic       unlocked, locked_out, code_valid;
    logic [1:0] fail_cnt;
    logic [2:0] state_o;
`ifdef LOCK_ALARM_EN
    logic       alarm;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: attempt held as a decimal number plus digit count.
    int m_state, m_val, m_cnt, m_code, m_pend, m_fails, m_left;
    bit m_valid;

    lock_supervisor #(
        .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .UNLOCK_CYCLES(UNLOCK_CYCLES), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .pressed(pressed), .submit(submit),
        .set_req(set_req), .unlocked(unlocked), .locked_out(locked_out),
        .code_valid(code_valid), .fail_cnt(fail_cnt),
`ifdef LOCK_ALARM_EN
        .alarm(alarm),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = S_NOCODE; m_val = 0; m_cnt = 0; m_code = 0; m_pend = 0;
        m_fails = 0; m_left = 0; m_valid = 1'b0;
    endtask

    task automatic model_step(input int k, input bit p, input bit s, input bit r);
        int  cur  = m_val;
        bit  full = (m_cnt == DIGITS);
        bit  cap  = (m_state == S_NOCODE) || (m_state == S_ARMED) ||
                    (m_state == S_SET_NEW) || (m_state == S_SET_CONF);
        int  ret  = m_valid ? S_ARMED : S_NOCODE;
        if (s) begin
            m_val = 0; m_cnt = 0;
        end else if (cap && p && k < 10) begin
            m_val = (m_val * 10 + k) % MOD;
            if (m_cnt < DIGITS) m_cnt++;
        end
        case (m_state)
            S_NOCODE: if (r) m_state = S_SET_NEW;
            S_ARMED: if (s) begin
                if (full && cur == m_code) begin
                    m_state = S_OPEN; m_left = UNLOCK_CYCLES; m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails >= MAX_FAILS) begin
                        m_fails = MAX_FAILS; m_state = S_LOCKOUT; m_left = LOCKOUT_CYCLES;
                    end
                end
            end
            S_OPEN: if (r) m_state = S_SET_NEW;
                    else begin
                        m_left--;
                        if (m_left == 0) m_state = S_ARMED;
                    end
            S_LOCKOUT: begin
                m_left--;
                if (m_left == 0) begin m_state = S_ARMED; m_fails = 0; end
            end
            S_SET_NEW: if (s) begin
                if (full) begin m_pend = cur; m_state = S_SET_CONF; end
                else m_state = ret;
            end
            S_SET_CONF: if (s) begin
                if (full && cur == m_pend) begin m_code = cur; m_valid = 1'b1; m_state = S_ARMED; end
                else m_state = ret;
            end
            default: m_state = S_NOCODE;
        endcase
    endtask

    function automatic logic [7:0] exp_vec();
        return {3'(m_state), m_state == S_OPEN, m_state == S_LOCKOUT, m_valid, 2'(m_fails)};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {state_o, unlocked, locked_out, code_valid, fail_cnt};
    endfunction

    // One clock: drive inputs, advance the model, settle 1 time unit past the edge.
    task automatic cycle(input int k, input bit p, input bit s, input bit r);
        key = 4'(k); pressed = p; submit = s; set_req = r;
        model_step(k, p, s, r);
        @(posedge clk);
        #1;
        key = 4'd0; pressed = 1'b0; submit = 1'b0; set_req = 1'b0;
    endtask

    task automatic type_code(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            int d = (val / (10 ** (n - 1 - i))) % 10;
            cycle(d, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: got %b want %b", obs_vec(), 8'h00);
        end
        rst_n = 1'b1;
        cycle(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_program();
        cycle(0, 1'b0, 1'b0, 1'b1);
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL program_first_pass: got %b want %b", obs_vec(), exp_vec());
        end
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({code_valid, state_o, unlocked} !== {1'b1, 3'(S_ARMED), 1'b0}) begin
            n_bad++;
            $display("FAIL program_confirm: got valid=%b state=%0d unl=%b want 1/%0d/0",
                     code_valid, state_o, unlocked, S_ARMED);
        end
    endtask

    task automatic test_open();
        int high = 0;
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= UNLOCK_CYCLES + 1; i++) begin
            n_cmp++;
            if (unlocked !== 1'(i <= UNLOCK_CYCLES)) begin
                n_bad++;
                $display("FAIL open_window_N+%0d: got unlocked=%b want %b", i, unlocked, i <= UNLOCK_CYCLES);
            end
            if (unlocked === 1'b1) high++;
            if (i <= UNLOCK_CYCLES) cycle($urandom_range(0, 9), 1'b1, 1'(i == 3), 1'b0);
        end
        n_cmp++;
        if (high !== UNLOCK_CYCLES || fail_cnt !== 2'd0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL open_length: got %0d cycles fail=%0d vec=%b want %0d cycles fail=0 vec=%b",
                     high, fail_cnt, obs_vec(), UNLOCK_CYCLES, exp_vec());
        end
    endtask

    task automatic test_lockout();
        int lo = 0;
        for (int f = 1; f <= MAX_FAILS; f++) begin
            type_code(9999, 4);
            cycle(0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (f < MAX_FAILS && fail_cnt !== 2'(f)) begin
                n_bad++;
                $display("FAIL lockout_fail_step%0d: got %0d want %0d", f, fail_cnt, f);
            end else if (f == MAX_FAILS && locked_out !== 1'b1) begin
                n_bad++;
                $display("FAIL lockout_entry: got locked_out=%b want 1", locked_out);
            end
        end
        for (int i = 0; i < LOCKOUT_CYCLES + 6; i++) begin
            if (locked_out === 1'b1) lo++;
            n_cmp++;
            if (unlocked !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL lockout_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i >= 5 && i <= 8) cycle(i - 4, 1'b1, 1'b0, 1'b0);
            else cycle(0, 1'b0, 1'(i == 9), 1'(i == 20));
        end
        n_cmp++;
        if (lo !== LOCKOUT_CYCLES || fail_cnt !== 2'd0 || state_o !== 3'(S_ARMED)) begin
            n_bad++;
            $display("FAIL lockout_length: got %0d cycles fail=%0d state=%0d want %0d/0/%0d",
                     lo, fail_cnt, state_o, LOCKOUT_CYCLES, S_ARMED);
        end
    endtask

    task automatic test_invalid_key();
        type_code(51, 2);
        cycle(12, 1'b1, 1'b0, 1'b0);
        type_code(234, 3);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (unlocked !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL invalid_key_open: got %b want unlocked vec %b", obs_vec(), exp_vec());
        end
        repeat (UNLOCK_CYCLES) cycle(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_submit_priority();
        type_code(123, 3);
        cycle(4, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (fail_cnt !== 2'd1 || unlocked !== 1'b0) begin
            n_bad++;
            $display("FAIL submit_priority: got fail=%0d unl=%b want 1/0", fail_cnt, unlocked);
        end
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (fail_cnt !== 2'd0 || unlocked !== 1'b1) begin
            n_bad++;
            $display("FAIL submit_priority_recover: got fail=%0d unl=%b want 0/1", fail_cnt, unlocked);
        end
        repeat (UNLOCK_CYCLES) cycle(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reprogram_mismatch();
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(0, 1'b0, 1'b0, 1'b0);
        cycle(0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (unlocked !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reprog_enter: got %b want %b", obs_vec(), exp_vec());
        end
        type_code(5678, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        type_code(5679, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (state_o !== 3'(S_ARMED) || code_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_mismatch: got state=%0d valid=%b want %0d/1", state_o, code_valid, S_ARMED);
        end
        type_code(1234, 4);
        cycle(0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (unlocked !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_old_code: got unlocked=%b want 1", unlocked);
        end
        repeat (UNLOCK_CYCLES) cycle(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] seq[$];
        for (int it = 0; it < 400; it++) begin
            int act = $urandom_range(0, 7);
            seq.delete();
            if (act <= 3) begin
                for (int j = 0; j < 4; j++)
                    seq.push_back({4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0)});
            end else if (act == 4) begin
                for (int i = 0; i < DIGITS; i++)
                    seq.push_back({4'((m_code / (10 ** (DIGITS - 1 - i))) % 10), 3'b100});
                seq.push_back(7'b0000010);
            end else if (act == 5) begin
                int v = $urandom_range(0, MOD - 1);
                int n1 = $urandom_range(3, 5);
                int n2 = $urandom_range(3, 5);
                int v2 = ($urandom_range(0, 1) != 0) ? v : $urandom_range(0, MOD - 1);
                seq.push_back(7'b0000001);
                for (int i = 0; i < n1; i++) seq.push_back({4'((v / (10 ** (i % 4))) % 10), 3'b100});
                seq.push_back(7'b0000010);
                for (int i = 0; i < n2; i++) seq.push_back({4'((v2 / (10 ** (i % 4))) % 10), 3'b100});
                seq.push_back(7'b0000010);
            end else if (act == 6) begin
                repeat ($urandom_range(0, 15)) seq.push_back(7'b0);
            end else if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                #2;
                model_reset();
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random_reset it%0d: got %b want %b", it, obs_vec(), exp_vec());
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            foreach (seq[j]) begin
                cycle(int'(seq[j][6:3]), seq[j][2], seq[j][1], seq[j][0]);
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random it%0d step%0d: got %b want %b", it, j, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_program();
        test_open();
        test_lockout();
        test_invalid_key();
        test_submit_priority();
        test_reprogram_mismatch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
